// File: rtl/persiana_pkg.sv
// Shared level codes, controller state type and counter sizing helper
// for the blind motor controller.
package persiana_pkg;

   localparam logic [1:0] LVL_CERRADO = 2'b00;
   localparam logic [1:0] LVL_MEDIO   = 2'b01;
   localparam logic [1:0] LVL_ABIERTO = 2'b10;
   localparam logic [1:0] LVL_INVALID = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOVE_UP,
      ST_MOVE_DOWN,
      ST_DEAD,
      ST_FAULT
   } persiana_state_e;

   // Width wide enough to hold the larger of two cycle counts.
   function automatic int cnt_width(input int a, input int b);
      return (a > b) ? $clog2(a) + 1 : $clog2(b) + 1;
   endfunction

endpackage

// File: rtl/persiana_motor_ctrl_if.sv
// Request, limit-switch and motor-driver signals of the blind controller.
// The master side issues requests and senses limits; the slave is the controller.
interface persiana_motor_ctrl_if;

   logic       req_man_valid;
   logic [1:0] req_man_level;
   logic       req_auto_valid;
   logic [1:0] req_auto_level;
   logic       lim_top;
   logic       lim_bot;
   logic       mot_up;
   logic       mot_down;
   logic [1:0] pos;
   logic       busy;
   logic       done;
   logic       fault;

   modport master (
      output req_man_valid, req_man_level, req_auto_valid, req_auto_level,
      output lim_top, lim_bot,
      input  mot_up, mot_down, pos, busy, done, fault
   );

   modport slave (
      input  req_man_valid, req_man_level, req_auto_valid, req_auto_level,
      input  lim_top, lim_bot,
      output mot_up, mot_down, pos, busy, done, fault
   );

endinterface

// File: rtl/persiana_cnt.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module persiana_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/persiana_motor_ctrl.sv
// Blind motor sequencer: arbitrates manual/auto level requests, times the
// per-level travel, inserts dead-time between moves and watches the limit switches.
module persiana_motor_ctrl
   import persiana_pkg::*;
#(
   parameter int STEP_CYCLES     = 1000,
   parameter int DEAD_CYCLES     = 16,
   parameter int MAN_HOLD_CYCLES = 5000
) (
   input logic                  reloj,
   input logic                  reset,
   persiana_motor_ctrl_if.slave bus
);

   localparam int STEP_W = cnt_width(STEP_CYCLES, DEAD_CYCLES);
   localparam int HOLD_W = cnt_width(MAN_HOLD_CYCLES, 1);

   // The step/dead counter is loaded with N-1 so that its zero flag marks the
   // last cycle of an N-cycle interval.
   localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES - 1);
   localparam logic [STEP_W-1:0] DEAD_LOAD = STEP_W'(DEAD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MAN_HOLD_CYCLES);

   persiana_state_e state_q;
   persiana_state_e state_d;
   logic [1:0]      pos_q;
   logic [1:0]      pos_d;
   logic [1:0]      target_q;
   logic [1:0]      target_d;
   logic            done_q;
   logic            done_d;

   logic              step_load;
   logic [STEP_W-1:0] step_val;
   logic              step_zero;
   logic              hold_load;
   logic              hold_zero;

   logic       man_ok;
   logic       auto_ok;
   logic [1:0] req_lvl;
   logic       moving_up;
   logic [1:0] eff_target;
   logic [1:0] pos_next;

   assign man_ok  = bus.req_man_valid && (bus.req_man_level != LVL_INVALID);
   assign auto_ok = bus.req_auto_valid && (bus.req_auto_level != LVL_INVALID) && hold_zero;

   persiana_cnt #(.WIDTH(STEP_W)) u_step_cnt (
      .clk      (reloj),
      .rst      (reset),
      .load     (step_load),
      .load_val (step_val),
      .dec      (1'b1),
      .zero     (step_zero)
   );

   persiana_cnt #(.WIDTH(HOLD_W)) u_hold_cnt (
      .clk      (reloj),
      .rst      (reset),
      .load     (hold_load),
      .load_val (HOLD_LOAD),
      .dec      (1'b1),
      .zero     (hold_zero)
   );

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      target_d   = target_q;
      done_d     = 1'b0;
      step_load  = 1'b0;
      step_val   = STEP_LOAD;
      hold_load  = 1'b0;
      req_lvl    = man_ok ? bus.req_man_level : bus.req_auto_level;
      moving_up  = (state_q == ST_MOVE_UP);
      eff_target = target_q;
      pos_next   = moving_up ? (pos_q + 2'd1) : (pos_q - 2'd1);

      if (bus.lim_top && bus.lim_bot) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (man_ok || auto_ok) begin
                  hold_load = man_ok;
                  if (req_lvl == pos_q) begin
                     done_d = 1'b1;
                  end else begin
                     target_d  = req_lvl;
                     step_load = 1'b1;
                     step_val  = STEP_LOAD;
                     state_d   = (req_lvl > pos_q) ? ST_MOVE_UP : ST_MOVE_DOWN;
                  end
               end
            end

            ST_MOVE_UP, ST_MOVE_DOWN: begin
               if (moving_up ? bus.lim_top : bus.lim_bot) begin
                  pos_d     = moving_up ? LVL_ABIERTO : LVL_CERRADO;
                  target_d  = moving_up ? LVL_ABIERTO : LVL_CERRADO;
                  state_d   = ST_DEAD;
                  step_load = 1'b1;
                  step_val  = DEAD_LOAD;
               end else if (man_ok && ((bus.req_man_level == pos_q) ||
                                       ((bus.req_man_level > pos_q) != moving_up))) begin
                  // Stop or reversal: the new target is picked up after the dead time.
                  hold_load = 1'b1;
                  target_d  = bus.req_man_level;
                  state_d   = ST_DEAD;
                  step_load = 1'b1;
                  step_val  = DEAD_LOAD;
               end else begin
                  if (man_ok) begin
                     hold_load  = 1'b1;
                     target_d   = bus.req_man_level;
                     eff_target = bus.req_man_level;
                  end
                  if (step_zero) begin
                     pos_d     = pos_next;
                     step_load = 1'b1;
                     if (pos_next == eff_target) begin
                        state_d  = ST_DEAD;
                        step_val = DEAD_LOAD;
                     end else begin
                        step_val = STEP_LOAD;
                     end
                  end
               end
            end

            ST_DEAD: begin
               if (step_zero) begin
                  if (target_q != pos_q) begin
                     state_d   = (target_q > pos_q) ? ST_MOVE_UP : ST_MOVE_DOWN;
                     step_load = 1'b1;
                     step_val  = STEP_LOAD;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end

            ST_FAULT: begin
               state_d = ST_FAULT;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge reloj or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pos_q    <= LVL_CERRADO;
         target_q <= LVL_CERRADO;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         target_q <= target_d;
         done_q   <= done_d;
      end
   end

   assign bus.mot_up   = (state_q == ST_MOVE_UP);
   assign bus.mot_down = (state_q == ST_MOVE_DOWN);
   assign bus.pos      = pos_q;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.done     = done_q;
   assign bus.fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_persiana_motor_ctrl.sv
// Bench for the blind motor controller: directed vector table, hand-written
// corner sequences, then random traffic checked against a countdown model.
module tb_persiana_motor_ctrl;
   import persiana_pkg::*;

   localparam int STEP = 8;
   localparam int DEAD = 2;
   localparam int HOLD = 20;

   typedef struct packed {
      logic       man_valid;
      logic [1:0] man_level;
      logic       auto_valid;
      logic [1:0] auto_level;
      logic       lim_top;
      logic       lim_bot;
   } stim_t;

   typedef struct packed {
      stim_t      stim;
      logic [6:0] exp;
   } vec_t;

   logic reloj = 1'b0;
   logic reset;

   persiana_motor_ctrl_if bus ();

   persiana_motor_ctrl #(
      .STEP_CYCLES     (STEP),
      .DEAD_CYCLES     (DEAD),
      .MAN_HOLD_CYCLES (HOLD)
   ) dut (
      .reloj (reloj),
      .reset (reset),
      .bus   (bus)
   );

   always #5 reloj = ~reloj;

   vec_t vectors[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: motion expressed as cycles left in the current step and
   // in the dead interval, plus a direction of travel.
   int m_pos, m_target, m_dir, m_left, m_dead, m_hold;
   bit m_fault, m_done;

   function automatic stim_t mk_stim(input logic mv, input logic [1:0] ml, input logic av,
                                     input logic [1:0] al, input logic lt, input logic lb);
      stim_t s;
      s.man_valid  = mv;
      s.man_level  = ml;
      s.auto_valid = av;
      s.auto_level = al;
      s.lim_top    = lt;
      s.lim_bot    = lb;
      return s;
   endfunction

   // Packed as {mot_up, mot_down, pos, busy, done, fault}.
   function automatic logic [6:0] mk_exp(input logic up, input logic dn, input logic [1:0] p,
                                         input logic bz, input logic dn_pulse, input logic ft);
      return {up, dn, p, bz, dn_pulse, ft};
   endfunction

   function automatic logic [6:0] dut_out();
      return {bus.mot_up, bus.mot_down, bus.pos, bus.busy, bus.done, bus.fault};
   endfunction

   function automatic int sgn(input int v);
      return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
   endfunction

   function automatic logic [6:0] model_out();
      return mk_exp(!m_fault && (m_dir == 1), !m_fault && (m_dir == -1), 2'(m_pos),
                    m_fault || (m_dir != 0) || (m_dead > 0), m_done, m_fault);
   endfunction

   task automatic model_reset();
      m_pos = 0; m_target = 0; m_dir = 0; m_left = 0; m_dead = 0; m_hold = 0;
      m_fault = 1'b0; m_done = 1'b0;
   endtask

   task automatic model_step(input stim_t s);
      int hold_next;
      int lvl;
      bit man_ok;
      bit auto_ok;
      bit new_done;
      bit stopped;
      new_done  = 1'b0;
      stopped   = 1'b0;
      hold_next = (m_hold > 0) ? m_hold - 1 : 0;
      man_ok    = s.man_valid && (s.man_level != 2'b11);
      auto_ok   = s.auto_valid && (s.auto_level != 2'b11) && (m_hold == 0);
      if (m_fault) begin
         m_dir = 0;
      end else if (s.lim_top && s.lim_bot) begin
         m_fault = 1'b1; m_dir = 0; m_dead = 0;
      end else if (m_dir != 0) begin
         if ((m_dir == 1 && s.lim_top) || (m_dir == -1 && s.lim_bot)) begin
            m_pos = (m_dir == 1) ? 2 : 0;
            m_target = m_pos; m_dir = 0; m_dead = DEAD;
         end else begin
            if (man_ok) begin
               hold_next = HOLD;
               lvl = int'(s.man_level);
               m_target = lvl;
               if (sgn(lvl - m_pos) != m_dir) begin
                  m_dir = 0; m_dead = DEAD; stopped = 1'b1;
               end
            end
            if (!stopped) begin
               m_left--;
               if (m_left == 0) begin
                  m_pos += m_dir;
                  if (m_pos == m_target) begin
                     m_dir = 0; m_dead = DEAD;
                  end else begin
                     m_left = STEP;
                  end
               end
            end
         end
      end else if (m_dead > 0) begin
         m_dead--;
         if (m_dead == 0) begin
            if (m_target != m_pos) begin
               m_dir = sgn(m_target - m_pos); m_left = STEP;
            end else begin
               new_done = 1'b1;
            end
         end
      end else if (man_ok || auto_ok) begin
         lvl = man_ok ? int'(s.man_level) : int'(s.auto_level);
         if (man_ok) hold_next = HOLD;
         if (lvl == m_pos) begin
            new_done = 1'b1;
         end else begin
            m_target = lvl; m_dir = sgn(lvl - m_pos); m_left = STEP;
         end
      end
      m_hold = hold_next;
      m_done = new_done;
   endtask

   task automatic drive(input stim_t s);
      bus.req_man_valid  = s.man_valid;
      bus.req_man_level  = s.man_level;
      bus.req_auto_valid = s.auto_valid;
      bus.req_auto_level = s.auto_level;
      bus.lim_top        = s.lim_top;
      bus.lim_bot        = s.lim_bot;
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic apply_stimulus(input stim_t s);
      drive(s);
      @(posedge reloj);
      model_step(s);
      @(negedge reloj);
   endtask

   task automatic check_output(input string name, input logic [6:0] exp);
      logic [6:0] got;
      got = dut_out();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %b expected %b (up,down,pos,busy,done,fault)", name, got, exp);
      end
   endtask

   task automatic check_value(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(mk_stim(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
      model_reset();
      repeat (2) @(negedge reloj);
      reset = 1'b0;
   endtask

   task automatic add_vec(input stim_t s, input logic [6:0] e);
      vec_t v;
      v.stim = s;
      v.exp  = e;
      vectors.push_back(v);
   endtask

   initial begin
      stim_t idle_s;
      stim_t rs;
      int    low_cnt;
      int    down_cnt;
      int    up_cnt;
      int    done_cnt;
      int    r;

      idle_s = mk_stim(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

      // Two-level raise from closed, then invalid / same-level requests.
      add_vec(mk_stim(1'b1, LVL_ABIERTO, 1'b0, 2'b00, 1'b0, 1'b0),
              mk_exp(1'b1, 1'b0, LVL_CERRADO, 1'b1, 1'b0, 1'b0));
      for (int i = 1; i <= 15; i++)
         add_vec(idle_s, mk_exp(1'b1, 1'b0, (i >= 8) ? LVL_MEDIO : LVL_CERRADO, 1'b1, 1'b0, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b1, 1'b0, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b1, 1'b0, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b0, 1'b1, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b0, 1'b0, 1'b0));
      add_vec(mk_stim(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0),
              mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b0, 1'b0, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b0, 1'b0, 1'b0));
      add_vec(mk_stim(1'b0, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0),
              mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b0, 1'b0, 1'b0));
      add_vec(mk_stim(1'b1, LVL_ABIERTO, 1'b0, 2'b00, 1'b0, 1'b0),
              mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b0, 1'b1, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b0, 1'b0, 1'b0));

      // Manual beats auto in the same cycle; auto is then held off for HOLD cycles.
      add_vec(mk_stim(1'b1, LVL_MEDIO, 1'b1, LVL_ABIERTO, 1'b0, 1'b0),
              mk_exp(1'b0, 1'b1, LVL_ABIERTO, 1'b1, 1'b0, 1'b0));
      for (int i = 1; i <= 7; i++)
         add_vec(idle_s, mk_exp(1'b0, 1'b1, LVL_ABIERTO, 1'b1, 1'b0, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_MEDIO, 1'b1, 1'b0, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_MEDIO, 1'b1, 1'b0, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_MEDIO, 1'b0, 1'b1, 1'b0));
      for (int i = 11; i <= 19; i++)
         add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_MEDIO, 1'b0, 1'b0, 1'b0));
      add_vec(mk_stim(1'b0, 2'b00, 1'b1, LVL_CERRADO, 1'b0, 1'b0),
              mk_exp(1'b0, 1'b0, LVL_MEDIO, 1'b0, 1'b0, 1'b0));
      add_vec(mk_stim(1'b0, 2'b00, 1'b1, LVL_CERRADO, 1'b0, 1'b0),
              mk_exp(1'b0, 1'b1, LVL_MEDIO, 1'b1, 1'b0, 1'b0));
      for (int i = 1; i <= 7; i++)
         add_vec(idle_s, mk_exp(1'b0, 1'b1, LVL_MEDIO, 1'b1, 1'b0, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_CERRADO, 1'b1, 1'b0, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_CERRADO, 1'b1, 1'b0, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_CERRADO, 1'b0, 1'b1, 1'b0));
      add_vec(idle_s, mk_exp(1'b0, 1'b0, LVL_CERRADO, 1'b0, 1'b0, 1'b0));

      do_reset();
      check_output("reset", mk_exp(1'b0, 1'b0, LVL_CERRADO, 1'b0, 1'b0, 1'b0));

      for (int i = 0; i < vectors.size(); i++) begin
         apply_stimulus(vectors[i].stim);
         check_output($sformatf("table[%0d]", i), vectors[i].exp);
      end

      // Top limit three cycles into a raise.
      apply_stimulus(mk_stim(1'b1, LVL_ABIERTO, 1'b0, 2'b00, 1'b0, 1'b0));
      check_output("lim_start", mk_exp(1'b1, 1'b0, LVL_CERRADO, 1'b1, 1'b0, 1'b0));
      apply_stimulus(idle_s);
      apply_stimulus(idle_s);
      check_output("lim_moving", mk_exp(1'b1, 1'b0, LVL_CERRADO, 1'b1, 1'b0, 1'b0));
      apply_stimulus(mk_stim(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0));
      check_output("lim_stop", mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b1, 1'b0, 1'b0));
      apply_stimulus(idle_s);
      check_output("lim_dead", mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b1, 1'b0, 1'b0));
      apply_stimulus(idle_s);
      check_output("lim_done", mk_exp(1'b0, 1'b0, LVL_ABIERTO, 1'b0, 1'b1, 1'b0));

      // Reversal: from half toward open, manual closed four cycles in.
      apply_stimulus(mk_stim(1'b1, LVL_MEDIO, 1'b0, 2'b00, 1'b0, 1'b0));
      repeat (10) apply_stimulus(idle_s);
      check_output("rev_setup", mk_exp(1'b0, 1'b0, LVL_MEDIO, 1'b0, 1'b1, 1'b0));
      apply_stimulus(mk_stim(1'b1, LVL_ABIERTO, 1'b0, 2'b00, 1'b0, 1'b0));
      check_output("rev_up", mk_exp(1'b1, 1'b0, LVL_MEDIO, 1'b1, 1'b0, 1'b0));
      repeat (3) apply_stimulus(idle_s);
      low_cnt = 0; down_cnt = 0; up_cnt = 0; done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 0) apply_stimulus(mk_stim(1'b1, LVL_CERRADO, 1'b0, 2'b00, 1'b0, 1'b0));
         else        apply_stimulus(idle_s);
         if (!bus.mot_up && !bus.mot_down && down_cnt == 0) low_cnt++;
         if (bus.mot_down) down_cnt++;
         if (bus.mot_up) up_cnt++;
         if (bus.done) done_cnt++;
      end
      check_value("rev_dead_cycles", low_cnt, DEAD);
      check_value("rev_down_cycles", down_cnt, STEP);
      check_value("rev_up_cycles", up_cnt, 0);
      check_value("rev_done_pulses", done_cnt, 1);
      check_value("rev_pos", int'(bus.pos), 0);

      // Both limits together latch the fault until reset.
      apply_stimulus(mk_stim(1'b1, LVL_ABIERTO, 1'b0, 2'b00, 1'b0, 1'b0));
      apply_stimulus(idle_s);
      apply_stimulus(mk_stim(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1));
      check_output("fault_enter", mk_exp(1'b0, 1'b0, LVL_CERRADO, 1'b1, 1'b0, 1'b1));
      apply_stimulus(mk_stim(1'b1, LVL_MEDIO, 1'b0, 2'b00, 1'b0, 1'b0));
      repeat (4) apply_stimulus(idle_s);
      check_output("fault_sticky", mk_exp(1'b0, 1'b0, LVL_CERRADO, 1'b1, 1'b0, 1'b1));
      do_reset();
      check_output("fault_cleared", mk_exp(1'b0, 1'b0, LVL_CERRADO, 1'b0, 1'b0, 1'b0));

      // Reset between clock edges while driving up.
      apply_stimulus(mk_stim(1'b1, LVL_ABIERTO, 1'b0, 2'b00, 1'b0, 1'b0));
      repeat (9) apply_stimulus(idle_s);
      check_output("async_pre", mk_exp(1'b1, 1'b0, LVL_MEDIO, 1'b1, 1'b0, 1'b0));
      #2 reset = 1'b1;
      #1 check_output("async_reset", mk_exp(1'b0, 1'b0, LVL_CERRADO, 1'b0, 1'b0, 1'b0));
      model_reset();
      @(negedge reloj);
      reset = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         rs.man_valid  = ($urandom_range(0, 19) == 0);
         rs.man_level  = 2'($urandom_range(0, 3));
         rs.auto_valid = ($urandom_range(0, 5) == 0);
         rs.auto_level = 2'($urandom_range(0, 3));
         r = int'($urandom_range(0, 99));
         rs.lim_top    = (r < 2);
         rs.lim_bot    = (r >= 2) && (r < 4);
         apply_stimulus(rs);
         check_output($sformatf("random[%0d]", i), model_out());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
